// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island definitions: packet type codes,
// scheduler state encoding and default slot length.
package hdmi_packet_pkg;

    localparam int PACKET_CYCLES_DEF = 32;

    typedef enum logic [2:0] {
        PKT_NULL   = 3'd0,
        PKT_ACR    = 3'd1,
        PKT_SAMPLE = 3'd2,
        PKT_AVI    = 3'd3,
        PKT_AIF    = 3'd4
    } pkt_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/sample_credit_counter.sv
// Saturating count of audio samples waiting for a packet slot.
// Flags overflow when a sample arrives with the counter already full.
module sample_credit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (inc && !dec) begin
            if (count_q == MAX) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/data_island_scheduler.sv
// Fixed-priority scheduler handing HDMI data-island slots to
// pending ACR, audio sample and infoframe packet sources.
module data_island_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int PACKET_CYCLES = PACKET_CYCLES_DEF,
    parameter int CREDIT_WIDTH  = 4
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       slot_ready,
    input  logic       acr_req,
    input  logic       sample_req,
    output logic       pkt_valid,
    output logic [2:0] pkt_type,
    output logic       busy,
    output logic [3:0] overrun
);

    localparam int SCW = (PACKET_CYCLES > 1) ? $clog2(PACKET_CYCLES) : 1;
    localparam logic [SCW-1:0] LAST = SCW'(PACKET_CYCLES - 1);

    state_e            state_q, state_d;
    logic [SCW-1:0]    slot_cnt_q, slot_cnt_d;
    logic              acr_pend_q, acr_pend_d;
    logic              avi_pend_q, avi_pend_d;
    logic              aif_pend_q, aif_pend_d;
    logic              pkt_valid_q, pkt_valid_d;
    pkt_type_e         pkt_type_q, pkt_type_d;
    logic [3:0]        overrun_q, overrun_d;

    logic [CREDIT_WIDTH-1:0] credit;
    logic                    credit_ovf;
    logic                    accept;
    pkt_type_e               sel;
    logic g_acr, g_smp, g_avi, g_aif;

    // The last SEND cycle may already take the next slot back-to-back
    assign accept = slot_ready &&
                    (state_q == ST_IDLE || slot_cnt_q == LAST);

    always_comb begin
        sel = PKT_NULL;
        if (acr_pend_q) begin
            sel = PKT_ACR;
        end else if (credit != '0) begin
            sel = PKT_SAMPLE;
        end else if (avi_pend_q) begin
            sel = PKT_AVI;
        end else if (aif_pend_q) begin
            sel = PKT_AIF;
        end
    end

    assign g_acr = accept && sel == PKT_ACR;
    assign g_smp = accept && sel == PKT_SAMPLE;
    assign g_avi = accept && sel == PKT_AVI;
    assign g_aif = accept && sel == PKT_AIF;

    sample_credit_counter #(
        .WIDTH(CREDIT_WIDTH)
    ) u_credit (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .inc       (sample_req),
        .dec       (g_smp),
        .count     (credit),
        .overflow  (credit_ovf)
    );

    always_comb begin
        acr_pend_d = acr_req     | (acr_pend_q & ~g_acr);
        avi_pend_d = frame_start | (avi_pend_q & ~g_avi);
        aif_pend_d = frame_start | (aif_pend_q & ~g_aif);
        overrun_d  = {frame_start & aif_pend_q & ~g_aif,
                      frame_start & avi_pend_q & ~g_avi,
                      credit_ovf,
                      acr_req & acr_pend_q & ~g_acr};
    end

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        pkt_valid_d = 1'b0;
        pkt_type_d  = pkt_type_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_SEND;
                    slot_cnt_d  = '0;
                    pkt_valid_d = 1'b1;
                    pkt_type_d  = sel;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    slot_cnt_d  = '0;
                    pkt_valid_d = 1'b1;
                    pkt_type_d  = sel;
                end else if (slot_cnt_q == LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            slot_cnt_q  <= '0;
            acr_pend_q  <= 1'b0;
            avi_pend_q  <= 1'b0;
            aif_pend_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_type_q  <= PKT_NULL;
            overrun_q   <= '0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            acr_pend_q  <= acr_pend_d;
            avi_pend_q  <= avi_pend_d;
            aif_pend_q  <= aif_pend_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_type_q  <= pkt_type_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_type  = pkt_type_q;
    assign busy      = (state_q == ST_SEND);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Scoreboard bench: expected packet types are queued as slots are
// offered and compared whenever a grant appears.
module tb_data_island_scheduler;

    logic       clk_pixel = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       slot_ready = 1'b0;
    logic       acr_req = 1'b0;
    logic       sample_req = 1'b0;
    logic       pkt_valid;
    logic [2:0] pkt_type;
    logic       busy;
    logic [3:0] overrun;

    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];
    logic [3:0] ovr_seen = '0;

    always #5 clk_pixel = ~clk_pixel;

    data_island_scheduler dut (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .frame_start (frame_start),
        .slot_ready  (slot_ready),
        .acr_req     (acr_req),
        .sample_req  (sample_req),
        .pkt_valid   (pkt_valid),
        .pkt_type    (pkt_type),
        .busy        (busy),
        .overrun     (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk_pixel) begin
        ovr_seen = ovr_seen | overrun;
        if (!reset && pkt_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 1, 0);
            end else begin
                chk("pkt_type", {29'd0, pkt_type}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_pixel);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        settle();
        while (busy !== 1'b0 && n < 200) begin
            settle();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic slot(input int exp, input logic acr, input logic fs);
        if (exp >= 0) exp_q.push_back(exp);
        slot_ready  = 1'b1;
        acr_req     = acr;
        frame_start = fs;
        tick();
        slot_ready  = 1'b0;
        acr_req     = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic busy_len(input string tag);
        int n;
        n = 0;
        settle();
        while (busy === 1'b1 && n < 100) begin
            n++;
            settle();
        end
        chk(tag, n, 32);
    endtask

    task automatic sb_empty(input string tag);
        settle();
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_valid", pkt_valid, 0);
        chk("rst_type", pkt_type, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_credit", dut.u_credit.count, 0);
        reset = 1'b0;
        tick();

        // empty slot -> NULL grant, 32 busy cycles
        slot(0, 1'b0, 1'b0);
        busy_len("busy_len_null");
        sb_empty("sb_null");

        // all sources pending -> priority order
        ovr_seen = '0;
        acr_req = 1'b1; sample_req = 1'b1; frame_start = 1'b1;
        tick();
        acr_req = 1'b0; sample_req = 1'b0; frame_start = 1'b0;
        slot(1, 1'b0, 1'b0); wait_idle();
        slot(2, 1'b0, 1'b0); wait_idle();
        slot(3, 1'b0, 1'b0); wait_idle();
        slot(4, 1'b0, 1'b0); wait_idle();
        slot(0, 1'b0, 1'b0); wait_idle();
        sb_empty("sb_prio");
        chk("ovr_prio", ovr_seen, 0);

        // credit saturation
        ovr_seen = '0;
        for (int i = 0; i < 16; i++) begin
            sample_req = 1'b1;
            tick();
            sample_req = 1'b0;
            if (i == 14) begin
                settle();
                chk("ovr_15", ovr_seen, 0);
            end
        end
        settle();
        chk("ovr_16", ovr_seen, 4'b0010);
        chk("credit_max", dut.u_credit.count, 15);
        for (int i = 0; i < 15; i++) begin
            slot(2, 1'b0, 1'b0);
            wait_idle();
        end
        slot(0, 1'b0, 1'b0); wait_idle();
        sb_empty("sb_credit");
        chk("credit_zero", dut.u_credit.count, 0);

        // slot during SEND ignored, accepted at t+32
        ovr_seen = '0;
        slot(0, 1'b0, 1'b0);
        repeat (4) tick();
        slot(-1, 1'b0, 1'b0);
        repeat (26) tick();
        slot(0, 1'b0, 1'b0);
        settle();
        chk("grant_t32", exp_q.size(), 0);
        chk("busy_t33", busy, 1);
        wait_idle();
        chk("ovr_send", ovr_seen, 0);

        // ACR request colliding with its own grant
        ovr_seen = '0;
        acr_req = 1'b1;
        tick();
        acr_req = 1'b0;
        slot(1, 1'b1, 1'b0);
        settle();
        chk("acr_pend_kept", dut.acr_pend_q, 1);
        chk("ovr_acr_none", ovr_seen, 0);
        acr_req = 1'b1;
        tick();
        acr_req = 1'b0;
        settle();
        chk("ovr_acr", ovr_seen, 4'b0001);
        wait_idle();
        slot(1, 1'b0, 1'b0); wait_idle();
        slot(0, 1'b0, 1'b0); wait_idle();
        sb_empty("sb_acr");

        // frame_start colliding with an infoframe grant
        ovr_seen = '0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        slot(3, 1'b0, 1'b0); wait_idle();
        slot(4, 1'b0, 1'b1); wait_idle();
        slot(3, 1'b0, 1'b0); wait_idle();
        slot(4, 1'b0, 1'b0); wait_idle();
        slot(0, 1'b0, 1'b0); wait_idle();
        sb_empty("sb_frame");
        chk("ovr_frame", ovr_seen, 0);

        // reset in the middle of a slot
        acr_req = 1'b1; sample_req = 1'b1; frame_start = 1'b1;
        tick();
        acr_req = 1'b0; sample_req = 1'b0; frame_start = 1'b0;
        slot(1, 1'b0, 1'b0);
        repeat (9) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_type", pkt_type, 0);
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_credit", dut.u_credit.count, 0);
        chk("mid_rst_pend",
            {dut.acr_pend_q, dut.avi_pend_q, dut.aif_pend_q}, 0);
        tick();
        reset = 1'b0;
        tick();
        slot(0, 1'b0, 1'b0);
        busy_len("busy_len_post_rst");
        sb_empty("sb_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
